key_autorepeat: RTL and testbench



---
 rtl/key_autorepeat.sv | 163 ++++++++++++++++
 tb/tb_key_autorepeat.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_autorepeat.sv
// key_autorepeat: conditions one raw push-button into clean single-cycle pulses.
// The chain is a 2-flop synchronizer, a stable-interval debouncer and an
// optional hold-to-repeat generator.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   defined     -> IDLE/DELAY/REPEAT auto-repeat FSM is built.
//   not defined -> trans_dn pulses only on an accepted press, repeating = 0,
//                  HOLD_CYCLES / REPEAT_CYCLES are ignored.
//
// Ports:
//   CLK          in   system clock, all logic on posedge
//   RST          in   synchronous active-high reset
//   switch_input in   raw asynchronous button, active-high
//   pressed      out  debounced button level
//   trans_dn     out  one-cycle pulse on accepted press and on each repeat
//   trans_up     out  one-cycle pulse on accepted release
//   repeating    out  high while the repeat FSM is in REPEAT
module key_autorepeat #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic switch_input,
  output logic pressed,
  output logic trans_dn,
  output logic trans_up,
  output logic repeating
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DLast = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          pressed_q, pressed_d;
  logic          trans_dn_q, trans_dn_d;
  logic          trans_up_q, trans_up_d;
  logic          repeating_q, repeating_d;
  logic          accept, press_acc, release_acc;

  // Debouncer: sync2 must differ from the debounced level for DEBOUNCE_CYCLES
  // consecutive cycles; any return to the current level restarts the count.
  always_comb begin
    dcnt_d = dcnt_q;
    accept = 1'b0;
    if (sync2_q == pressed_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DLast) begin
      dcnt_d = '0;
      accept = 1'b1;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign press_acc   = accept & sync2_q;
  assign release_acc = accept & ~sync2_q;
  assign pressed_d   = accept ? sync2_q : pressed_q;
  assign trans_up_d  = release_acc;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RW   = $clog2(RMax);
  localparam logic [RW-1:0] HLast = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RLast = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_pulse;

  // Release is checked first in DELAY/REPEAT so a terminal count coinciding
  // with the release edge never produces a trans_dn alongside trans_up.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rep_pulse = 1'b0;
    case (state_q)
      StIdle: begin
        if (press_acc) begin
          state_d = StDelay;
          rcnt_d  = '0;
        end
      end
      StDelay: begin
        if (release_acc) begin
          state_d = StIdle;
          rcnt_d  = '0;
        end else if (rcnt_q == HLast) begin
          rep_pulse = 1'b1;
          rcnt_d    = '0;
          state_d   = StRepeat;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      StRepeat: begin
        if (release_acc) begin
          state_d = StIdle;
          rcnt_d  = '0;
        end else if (rcnt_q == RLast) begin
          rep_pulse = 1'b1;
          rcnt_d    = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        rcnt_d  = '0;
      end
    endcase
  end

  assign trans_dn_d  = press_acc | rep_pulse;
  assign repeating_d = (state_d == StRepeat);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};

  assign trans_dn_d  = press_acc;
  assign repeating_d = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      dcnt_q      <= '0;
      pressed_q   <= 1'b0;
      trans_dn_q  <= 1'b0;
      trans_up_q  <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      sync1_q     <= switch_input;
      sync2_q     <= sync1_q;
      dcnt_q      <= dcnt_d;
      pressed_q   <= pressed_d;
      trans_dn_q  <= trans_dn_d;
      trans_up_q  <= trans_up_d;
      repeating_q <= repeating_d;
    end
  end

  assign pressed   = pressed_q;
  assign trans_dn  = trans_dn_q;
  assign trans_up  = trans_up_q;
  assign repeating = repeating_q;

endmodule

// File: tb/tb_key_autorepeat.sv
// Testbench for key_autorepeat: directed scenarios plus randomized button
// activity, compared every cycle against an elapsed-time reference model.
module tb_key_autorepeat;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;
  logic pressed, trans_dn, trans_up, repeating;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: synchronizer taps, run length of disagreement,
  // and cycles elapsed since the accepted press (-1 when not held).
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_pressed = 1'b0;
  logic m_dn = 1'b0, m_up = 1'b0, m_rep = 1'b0;
  int   m_run  = 0;
  int   m_held = -1;

  always #5 clk = ~clk;

  key_autorepeat #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .switch_input(sw),
    .pressed     (pressed),
    .trans_dn    (trans_dn),
    .trans_up    (trans_up),
    .repeating   (repeating)
  );

  task automatic model_step();
    logic acc;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0; m_dn = 0; m_up = 0; m_rep = 0;
      m_run = 0; m_held = -1;
    end else begin
      acc  = 1'b0;
      m_dn = 1'b0;
      m_up = 1'b0;
      if (m_s2 != m_pressed) begin
        m_run++;
        if (m_run == D) begin
          acc   = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (acc && m_s2) begin
        m_pressed = 1; m_dn = 1; m_held = 0;
      end else if (acc) begin
        m_pressed = 0; m_up = 1; m_held = -1; m_rep = 0;
      end else if (m_held >= 0) begin
`ifdef KEY_AUTOREPEAT_EN
        m_held++;
        if (m_held >= H && (m_held - H) % R == 0) m_dn = 1;
        m_rep = (m_held >= H);
`endif
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle to negedge.
  task automatic tick(input logic s, input logic r);
    sw  = s;
    rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int e = 1; e <= 3; e++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      n_checks++;
      if ({pressed, trans_dn, trans_up, repeating} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs e=%0d got %b want 0000", e,
                 {pressed, trans_dn, trans_up, repeating});
      end
    end
    for (int e = 1; e <= 8; e++) tick(1'b0, 1'b0);
    n_checks++;
    if ({pressed, trans_dn, trans_up, repeating} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 0000", {pressed, trans_dn, trans_up, repeating});
    end
  endtask

  // Press at edge 10, release at edge 60: the release acceptance at edge 65
  // lands on a repeat terminal count, exercising release priority.
  task automatic test_clean_press();
    for (int e = 1; e <= 75; e++) begin
      tick(e >= 10 && e < 60, 1'b0);
      n_checks++;
      if ({pressed, trans_dn, trans_up, repeating} !== {m_pressed, m_dn, m_up, m_rep}) begin
        n_fail++;
        $display("FAIL clean_model e=%0d got p/dn/up/rep=%b want %b", e,
                 {pressed, trans_dn, trans_up, repeating}, {m_pressed, m_dn, m_up, m_rep});
      end
      if (e == 15 || e == 16 || e == 14) begin
        n_checks++;
        if (trans_dn !== (e == 15)) begin
          n_fail++;
          $display("FAIL press_pulse e=%0d got %b want %b", e, trans_dn, e == 15);
        end
      end
`ifdef KEY_AUTOREPEAT_EN
      if (e == 34 || e == 35 || e == 40 || e == 45) begin
        n_checks++;
        if ({trans_dn, repeating} !== {e != 34, e != 34}) begin
          n_fail++;
          $display("FAIL repeat_pulse e=%0d got dn/rep=%b%b want %b%b", e, trans_dn, repeating,
                   e != 34, e != 34);
        end
      end
`else
      if (e == 35 || e == 40) begin
        n_checks++;
        if ({trans_dn, repeating} !== 2'b00) begin
          n_fail++;
          $display("FAIL no_repeat e=%0d got dn/rep=%b%b want 00", e, trans_dn, repeating);
        end
      end
`endif
      if (e == 65) begin
        n_checks++;
        if ({pressed, trans_dn, trans_up, repeating} !== 4'b0010) begin
          n_fail++;
          $display("FAIL release_priority got p/dn/up/rep=%b want 0010",
                   {pressed, trans_dn, trans_up, repeating});
        end
      end
    end
  endtask

  task automatic test_bounce();
    int dn_seen = 0;
    for (int e = 1; e <= 20; e++) begin
      tick((e <= 4) ? 1'(e % 2) : 1'b0, 1'b0);
      if (trans_dn === 1'b1 || pressed === 1'b1) dn_seen++;
      n_checks++;
      if ({pressed, trans_dn, trans_up, repeating} !== {m_pressed, m_dn, m_up, m_rep}) begin
        n_fail++;
        $display("FAIL bounce_model e=%0d got %b want %b", e,
                 {pressed, trans_dn, trans_up, repeating}, {m_pressed, m_dn, m_up, m_rep});
      end
    end
    n_checks++;
    if (dn_seen != 0) begin
      n_fail++;
      $display("FAIL bounce_no_press got %0d active cycles want 0", dn_seen);
    end
  endtask

  task automatic test_bounce_settle();
    int dn_count = 0;
    for (int e = 1; e <= 45; e++) begin
      tick((e >= 16 && e <= 18) || (e >= 20 && e <= 30), 1'b0);
      if (e <= 30 && trans_dn === 1'b1) dn_count++;
      n_checks++;
      if ({pressed, trans_dn, trans_up, repeating} !== {m_pressed, m_dn, m_up, m_rep}) begin
        n_fail++;
        $display("FAIL settle_model e=%0d got %b want %b", e,
                 {pressed, trans_dn, trans_up, repeating}, {m_pressed, m_dn, m_up, m_rep});
      end
      if (e == 25) begin
        n_checks++;
        if (trans_dn !== 1'b1) begin
          n_fail++;
          $display("FAIL settle_pulse got %b want 1", trans_dn);
        end
      end
    end
    n_checks++;
    if (dn_count != 1) begin
      n_fail++;
      $display("FAIL settle_count got %0d want 1", dn_count);
    end
  endtask

  // Hold into REPEAT, reset for one cycle at edge 50 with the button held.
  task automatic test_reset_mid();
    for (int e = 1; e <= 70; e++) begin
      tick(e <= 60, e == 50);
      n_checks++;
      if ({pressed, trans_dn, trans_up, repeating} !== {m_pressed, m_dn, m_up, m_rep}) begin
        n_fail++;
        $display("FAIL rstmid_model e=%0d got %b want %b", e,
                 {pressed, trans_dn, trans_up, repeating}, {m_pressed, m_dn, m_up, m_rep});
      end
      if (e == 50) begin
        n_checks++;
        if ({pressed, trans_dn, trans_up, repeating} !== 4'b0000) begin
          n_fail++;
          $display("FAIL rstmid_clear got %b want 0000", {pressed, trans_dn, trans_up, repeating});
        end
      end
      if (e >= 51 && e <= 56) begin
        n_checks++;
        if (trans_dn !== (e == 56)) begin
          n_fail++;
          $display("FAIL rstmid_repress e=%0d got %b want %b", e, trans_dn, e == 56);
        end
      end
    end
  endtask

`ifndef KEY_AUTOREPEAT_EN
  task automatic test_no_repeat();
    int dn_count = 0;
    int up_count = 0;
    for (int e = 1; e <= 120; e++) begin
      tick(e >= 5 && e < 105, 1'b0);
      if (trans_dn === 1'b1) dn_count++;
      if (trans_up === 1'b1) up_count++;
      n_checks++;
      if (repeating !== 1'b0) begin
        n_fail++;
        $display("FAIL norep_repeating e=%0d got %b want 0", e, repeating);
      end
    end
    n_checks++;
    if (dn_count != 1 || up_count != 1) begin
      n_fail++;
      $display("FAIL norep_counts got dn=%0d up=%0d want dn=1 up=1", dn_count, up_count);
    end
  endtask
`endif

  task automatic test_random();
    logic lvl = 1'b0;
    int   left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        lvl  = 1'($urandom_range(0, 1));
        left = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
      end
      left--;
      tick(lvl, $urandom_range(0, 299) == 0);
      n_checks++;
      if ({pressed, trans_dn, trans_up, repeating} !== {m_pressed, m_dn, m_up, m_rep}) begin
        n_fail++;
        $display("FAIL random_model i=%0d got %b want %b", i,
                 {pressed, trans_dn, trans_up, repeating}, {m_pressed, m_dn, m_up, m_rep});
      end
      if (trans_dn === 1'b1 && trans_up === 1'b1) begin
        n_fail++;
        $display("FAIL random_exclusive i=%0d got dn=1 up=1 want not both", i);
      end
    end
    for (int e = 0; e < 12; e++) tick(1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_bounce_settle();
    test_reset_mid();
`ifndef KEY_AUTOREPEAT_EN
    test_no_repeat();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
